// File: rtl/bram_data_port.sv
// ---------------------------------------------------------------------------
// bram_data_port
//
// Load/store front end for a 32-bit-wide data BRAM (port B). It accepts one
// byte, halfword or word request at a time. It checks alignment, drives the
// BRAM strobes in the accepting cycle, and returns a single response through a
// valid/ready handshake. Load data is lane-selected and then either zero- or
// sign-extended.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned    zero-extend (1) or sign-extend (0) load data
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   rsp_valid/ready response handshake
//   rsp_rdata       extended load data (0 for stores and errors)
//   rsp_err         misaligned or reserved-size request
//   enb/web/addrb/dinb/doutb  BRAM port B (one-cycle read latency)
//   err_count       saturating count of error responses
// ---------------------------------------------------------------------------
module bram_data_port #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  enb,
  output logic [3:0]            web,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dinb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic [7:0]            err_count
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t state;

  // Request fields captured at accept time. The response is formed from
  // these copies, so the request inputs are free to change afterwards.
  logic [1:0] lo_p0;
  logic [1:0] size_p0;
  logic       uns_p0;

  logic req_err;
  logic fire;
  logic store_go;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // The reserved size is always an error. Otherwise the access must be
  // naturally aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    logic bad;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane write enables for a store. Because misaligned requests never
  // reach this function, a half store shifts only by 0 or 2.
  function automatic logic [3:0] store_mask(input logic [1:0] size,
                                            input logic [1:0] lo);
    logic [3:0] m;
    unique case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = 4'b0011 << lo;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the right-aligned store data across every lane that it could
  // target. The write mask then selects the lane(s) that are actually
  // written.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] d;
    unique case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Select the addressed lane from the BRAM word, then extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic        [31:0] r;
    b  = word[{lo, 3'b000} +: 8];
    h  = word[{lo[1], 4'b0000} +: 16];
    sb = b;
    sh = h;
    unique case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : 32'(sb);
      SZ_HALF: r = uns ? {16'b0, h} : 32'(sh);
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0: request decode and BRAM strobes (combinational, same cycle)
  // -------------------------------------------------------------------------
  // req_ready is also held low while reset is asserted, so a request that is
  // presented during reset can never touch the BRAM.
  assign req_ready = (state == IDLE) && rst;
  assign req_err   = is_misaligned(req_size, req_addr[1:0]);
  assign fire      = req_valid && req_ready;
  assign enb       = fire && !req_err;
  assign store_go  = enb && req_we;

  // All BRAM controls read as zero unless a strobe is actually issued.
  assign addrb = enb      ? {req_addr[ADDR_WIDTH-1:2], 2'b00}    : '0;
  assign web   = store_go ? store_mask(req_size, req_addr[1:0])  : 4'b0000;
  assign dinb  = store_go ? store_lanes(req_size, req_wdata)     : '0;

  always_ff @(posedge clk) begin
    if (fire) begin
      lo_p0   <= req_addr[1:0];
      size_p0 <= req_size;
      uns_p0  <= req_unsigned;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: transaction FSM and response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      err_count <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            rsp_rdata <= '0;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
            end else begin
              state     <= RD_WAIT;
              rsp_err   <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          // doutb carries the word that was addressed in the accept cycle.
          rsp_rdata <= extend_load(doutb, size_p0, lo_p0, uns_p0);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (rsp_err) begin
              err_count <= sat_inc(err_count);
            end
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_data_port.sv
module tb_bram_data_port;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        enb;
  logic [3:0]  web;
  logic [14:0] addrb;
  logic [31:0] dinb;
  logic [31:0] doutb;
  logic [7:0]  err_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  bram_data_port #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Deterministic background contents for never-written words.
  function automatic logic [31:0] fill(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // BRAM port B model: read-first, one-cycle read latency, output held
  // while enb is low.
  logic [31:0] bmem [0:8191];
  bit          bwr  [0:8191];
  always @(posedge clk) begin
    if (enb) begin
      logic [31:0] cur;
      cur = bwr[addrb[14:2]] ? bmem[addrb[14:2]] : fill(int'(addrb[14:2]));
      doutb <= cur;
      for (int i = 0; i < 4; i++)
        if (web[i]) cur[8*i +: 8] = dinb[8*i +: 8];
      bmem[addrb[14:2]] <= cur;
      bwr[addrb[14:2]]  <= 1'b1;
    end
  end

  // Reference model: byte-addressed memory image.
  logic [7:0] ref_mem [0:32767];

  function automatic logic [31:0] model_load(input logic [14:0] addr,
                                             input logic [1:0] size,
                                             input bit uns);
    int     n;
    longint v;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
    if (!uns && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit we, input logic [1:0] size, input bit uns,
                     input logic [14:0] addr, input logic [31:0] wdata, input int hold);
    bit          err;
    int          n;
    int          lat;
    logic [3:0]  e_web;
    logic [31:0] e_din;
    logic [31:0] e_rd;
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && (addr % 4) != 0);
    n = 1 << size;
    e_web = 4'b0000;
    e_din = 32'd0;
    e_rd  = 32'd0;
    if (we && !err) begin
      e_web = 4'(((1 << n) - 1) << (addr % 4));
      if (size == 2'd0)      e_din = 32'(wdata[7:0]) * 32'h01010101;
      else if (size == 2'd1) e_din = 32'(wdata[15:0]) * 32'h00010001;
      else                   e_din = wdata;
    end
    if (!we && !err) e_rd = model_load(addr, size, uns);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    #1;
    chk("req_ready", 32'(req_ready), 32'd1);
    chk("enb", 32'(enb), 32'(!err));
    chk("web", 32'(web), 32'(e_web));
    chk("addrb", 32'(addrb), err ? 32'd0 : 32'(addr & 15'h7FFC));
    chk("dinb", dinb, e_din);
    if (we && !err)
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];

    @(negedge clk);
    // The request inputs now carry noise that must be ignored.
    req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = 15'($urandom); req_wdata = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      chk("enb_wait", 32'(enb), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), (we || err) ? 32'd1 : 32'd2);
    repeat (hold) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, e_rd);
      chk("hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("rsp_err", 32'(rsp_err), 32'(err));
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (err) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    #1;
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("err_count", 32'(err_count), 32'(exp_cnt));
  endtask

  // Word request aborted by a one-cycle reset pulse, applied in RD_WAIT
  // (load) or RESP (store).
  task automatic txn_abort(input bit we, input logic [14:0] addr, input logic [31:0] wdata);
    logic [14:0] a;
    a = addr & 15'h7FFC;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = a; req_wdata = wdata; rsp_ready = 1'b0;
    #1;
    chk("abort_enb", 32'(enb), 32'd1);
    if (we)
      for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
    @(negedge clk);
    chk("abort_pre_valid", 32'(rsp_valid), 32'(we));
    rst = 1'b0;
    #1;
    chk("abort_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    exp_cnt = 0;
    repeat (4) begin
      #1;
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("abort_err_count", 32'(err_count), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 8192; w++) begin
      logic [31:0] f;
      f = fill(w);
      for (int i = 0; i < 4; i++) ref_mem[4*w + i] = f[8*i +: 8];
    end

    // Reset, with a valid store presented throughout
    rst = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 15'h0100; req_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_enb", 32'(enb), 32'd0);
    chk("rst_web", 32'(web), 32'd0);
    chk("rst_addrb", 32'(addrb), 32'd0);
    chk("rst_dinb", dinb, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Word store/load
    txn(1'b1, 2'd2, 1'b0, 15'h0100, 32'hDEADBEEF, 0);
    txn(1'b0, 2'd2, 1'b0, 15'h0100, 32'd0, 0);
    // Byte store 0x80 at 0x0103, signed and unsigned loads
    txn(1'b1, 2'd0, 1'b0, 15'h0103, 32'h00000080, 0);
    txn(1'b0, 2'd0, 1'b0, 15'h0103, 32'd0, 0);
    txn(1'b0, 2'd0, 1'b1, 15'h0103, 32'd0, 0);
    // Upper half becomes 0x8001, then signed/unsigned half loads
    txn(1'b1, 2'd1, 1'b0, 15'h0102, 32'h00008001, 0);
    txn(1'b0, 2'd1, 1'b0, 15'h0102, 32'd0, 0);
    txn(1'b0, 2'd1, 1'b1, 15'h0102, 32'd0, 0);
    // Misaligned errors
    txn(1'b0, 2'd2, 1'b0, 15'h0101, 32'd0, 0);
    txn(1'b0, 2'd1, 1'b0, 15'h0003, 32'd0, 0);
    // Backpressure
    txn(1'b0, 2'd2, 1'b0, 15'h0100, 32'd0, 5);
    // Reset aborts, then confirm normal operation
    txn_abort(1'b0, 15'h0100, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 15'h0100, 32'd0, 0);
    txn_abort(1'b1, 15'h0200, 32'h12345678);
    txn(1'b0, 2'd2, 1'b0, 15'h0200, 32'd0, 1);

    // Random traffic concentrated on a small window so that loads hit stores
    for (int k = 0; k < 300; k++) begin
      logic [14:0] a;
      if ($urandom_range(0, 7) == 0) a = 15'($urandom);
      else                           a = 15'($urandom_range(0, 63));
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
          int'($urandom_range(0, 3)));
    end

    // Saturation of the error counter
    for (int k = 0; k < 256; k++)
      txn(1'($urandom), 2'd3, 1'b0, 15'($urandom), $urandom, 0);
    chk("err_count_sat", 32'(err_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_data_port.md
BRAM_DATA_PORT -- requirements
Module: bram_data_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, byte-address width of the data BRAM (32 KB).
REQ-002 Parameter DATA_WIDTH, default 32, BRAM word width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset), sampled on rising clk.
REQ-005 req_valid  input  1  load/store request present.
REQ-006 req_ready  output  1  block accepts the request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned or reserved-size request.
REQ-016 enb, web[3:0], addrb[ADDR_WIDTH-1:0], dinb[31:0]  outputs  BRAM port B controls.
REQ-017 doutb  input  32  BRAM port B read data, valid one cycle after an enb cycle, held while enb=0.
REQ-018 err_count  output  8  saturating count of error responses.

Function
REQ-019 FSM states IDLE, RD_WAIT, RESP; exactly one transaction outstanding.
REQ-020 req_ready SHALL be 1 only in IDLE; fire = req_valid & req_ready.
REQ-021 Error = (size 01 & addr[0]) | (size 10 & addr[1:0]!=0) | (size 11).
REQ-022 On a fire without error, enb SHALL be 1 in the same cycle, combinationally; otherwise enb=0.
REQ-023 addrb SHALL be {req_addr[ADDR_WIDTH-1:2], 2'b00} whenever enb=1.
REQ-024 Store web: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Loads and errors drive web=0000.
REQ-025 Store dinb: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-026 IDLE->RD_WAIT on an error-free load fire; IDLE->RESP on a store fire or an error fire.
REQ-027 In RD_WAIT, capture doutb into rsp_rdata, then go to RESP.
  - Byte lane: doutb[8*addr[1:0] +: 8].
  - Half lane: doutb[16*addr[1] +: 16].
  - Extension per req_unsigned.
  - Address, size and unsigned are registered at fire.
REQ-028 Latency from fire to rsp_valid: load 2 cycles; store or error 1 cycle.
REQ-029 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1.
  - RESP->IDLE on the cycle after rsp_valid & rsp_ready.
  - No new request is accepted in the handshake cycle.
REQ-030 An error fire SHALL NOT assert enb; rsp_err=1, rsp_rdata=0.
REQ-031 err_count SHALL increment by 1 on each error response handshake and saturate at 255.
REQ-032 Request inputs are ignored outside IDLE; changes to them do not affect the in-flight response.

Reset
REQ-033 With rst=0 at a rising edge, the block SHALL enter IDLE.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, err_count=0.
  - enb=0, web=0, addrb=0, dinb=0.
REQ-034 Reset asserted in RD_WAIT or RESP SHALL abort the transaction with no response.
  - A store already issued to the BRAM is not undone.
REQ-035 req_ready SHALL be 0 while rst=0.

Verification
REQ-036 Word store 0xDEADBEEF at 0x0100, then word load 0x0100.
  - Store: web=1111, addrb=0x0100.
  - Load: rsp_rdata=0xDEADBEEF 2 cycles after fire.
REQ-037 Byte store 0x80 at 0x0103, then loads of 0x0103.
  - Store: web=1000, dinb=0x80808080.
  - Signed load: rsp_rdata=0xFFFFFF80; unsigned load: 0x00000080.
REQ-038 Half load at 0x0102, memory word 0x8001xxxx.
  - Signed: 0xFFFF8001; unsigned: 0x00008001.
REQ-039 Word load at 0x0101 and half load at 0x0003.
  - Each gives rsp_err=1, rsp_rdata=0, no enb pulse.
  - err_count goes 0->1->2; 256 errors leave err_count=255.
REQ-040 Backpressure: rsp_ready held 0 for 5 cycles after a load response.
  - rsp_valid and rsp_rdata stay stable; req_ready=0 throughout.
  - IDLE resumes the cycle after the handshake.
REQ-041 rst=0 pulsed in RD_WAIT: no rsp_valid follows; the next request completes normally.
